// File: rtl/banked_lane_memory.sv
// rtl/banked_lane_memory.sv - N byte-lane banked data memory with request/response channels

module hippo_memory #(
    parameter int RowW = 10
) (
    input  logic            clk_i,
    input  logic            we,
    input  logic [RowW-1:0] addr,
    input  logic [7:0]      wdata,
    output logic [7:0]      rdata
);
    logic [7:0] mem [2**RowW];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end
endmodule

module banked_lane_memory #(
    parameter int    NumLanes        = 4,
    parameter int    AddrWidth       = 12,
    parameter bit    AllowMisaligned = 1'b1,
    parameter string MemFilePrefix   = "data_"
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic                        req_we_i,
    input  logic [AddrWidth-1:0]        req_addr_i,
    input  logic [$clog2(NumLanes):0]   req_size_i,
    input  logic                        req_sext_i,
    input  logic [8*NumLanes-1:0]       req_wdata_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [8*NumLanes-1:0]       rsp_rdata_o,
    output logic                        rsp_err_o
);
    localparam int LaneBits = $clog2(NumLanes);
    localparam int SizeW    = LaneBits + 1;
    localparam int DW       = 8 * NumLanes;
    localparam int RowW     = AddrWidth - LaneBits;

    // Bank preload images are bound by the implementation flow, not by this RTL.
    logic unused_mem_prefix;
    assign unused_mem_prefix = (MemFilePrefix == "");

    logic                req_accept;
    logic                stalled;
    logic                req_err;
    logic                size_bad;
    logic                range_bad;
    logic                align_bad;
    logic [LaneBits-1:0] req_low;
    logic [RowW-1:0]     req_row;
    logic [AddrWidth:0]  req_end;
    logic [SizeW-1:0]    req_nbytes;

    logic [RowW-1:0]     lane_row    [NumLanes];
    logic [RowW-1:0]     bank_addr   [NumLanes];
    logic                bank_we     [NumLanes];
    logic [7:0]          bank_wdata  [NumLanes];
    logic [7:0]          bank_rdata  [NumLanes];

    logic                s1_valid;
    logic                s1_err;
    logic                s1_we;
    logic                s1_sext;
    logic [LaneBits-1:0] s1_low;
    logic [SizeW-1:0]    s1_size;
    logic [RowW-1:0]     s1_row      [NumLanes];

    logic [DW-1:0]       asm_data;
    logic                s1_advance;

    assign stalled     = s1_valid && rsp_valid_o && !rsp_ready_i;
    assign req_ready_o = !stalled;
    assign req_accept  = req_valid_i && req_ready_o;
    assign s1_advance  = s1_valid && (!rsp_valid_o || rsp_ready_i);

    assign req_low    = req_addr_i[LaneBits-1:0];
    assign req_row    = req_addr_i[AddrWidth-1:LaneBits];
    assign req_nbytes = SizeW'(1) << req_size_i;
    assign req_end    = {1'b0, req_addr_i} + ((AddrWidth+1)'(1) << req_size_i);
    assign size_bad   = req_size_i > SizeW'(LaneBits);
    assign range_bad  = req_end > {1'b1, {AddrWidth{1'b0}}};
    assign req_err    = size_bad || range_bad || align_bad;

    always_comb begin
        align_bad = 1'b0;
        if (!AllowMisaligned) begin
            for (int b = 0; b < LaneBits; b++) begin
                if (SizeW'(b) < req_size_i && req_addr_i[b]) begin
                    align_bad = 1'b1;
                end
            end
        end
    end

    // Lane L holds byte idx = L - addr_low of the access; lanes below addr_low spill into the next row.
    always_comb begin
        for (int l = 0; l < NumLanes; l++) begin
            logic [LaneBits-1:0] idx;
            logic                active;
            idx           = LaneBits'(l) - req_low;
            active        = {1'b0, idx} < req_nbytes;
            lane_row[l]   = req_row + RowW'(LaneBits'(l) < req_low);
            bank_addr[l]  = stalled ? s1_row[l] : lane_row[l];
            bank_we[l]    = req_accept && req_we_i && !req_err && active;
            bank_wdata[l] = req_wdata_i[{idx, 3'b000} +: 8];
        end
    end

    for (genvar g = 0; g < NumLanes; g++) begin : g_bank
        hippo_memory #(
            .RowW (RowW)
        ) u_bank (
            .clk_i (clk_i),
            .we    (bank_we[g]),
            .addr  (bank_addr[g]),
            .wdata (bank_wdata[g]),
            .rdata (bank_rdata[g])
        );
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_we    <= 1'b0;
            s1_sext  <= 1'b0;
            s1_low   <= '0;
            s1_size  <= '0;
            for (int l = 0; l < NumLanes; l++) begin
                s1_row[l] <= '0;
            end
        end else if (!stalled) begin
            s1_valid <= req_accept;
            if (req_accept) begin
                s1_err  <= req_err;
                s1_we   <= req_we_i;
                s1_sext <= req_sext_i;
                s1_low  <= req_low;
                s1_size <= req_size_i;
                for (int l = 0; l < NumLanes; l++) begin
                    s1_row[l] <= lane_row[l];
                end
            end
        end
    end

    // Rotate lanes back into byte order, then truncate and extend from the top kept byte.
    always_comb begin
        logic [DW-1:0]       raw;
        logic [SizeW-1:0]    nbytes;
        logic                sign_bit;
        logic [LaneBits-1:0] lane;
        nbytes   = SizeW'(1) << s1_size;
        sign_bit = 1'b0;
        raw      = '0;
        asm_data = '0;
        for (int i = 0; i < NumLanes; i++) begin
            lane = LaneBits'(i) + s1_low;
            raw[8*i +: 8] = bank_rdata[lane];
            if ({1'b0, LaneBits'(i)} == nbytes - SizeW'(1)) begin
                sign_bit = raw[8*i+7];
            end
        end
        for (int i = 0; i < NumLanes; i++) begin
            if ({1'b0, LaneBits'(i)} < nbytes) begin
                asm_data[8*i +: 8] = raw[8*i +: 8];
            end else begin
                asm_data[8*i +: 8] = {8{s1_sext && sign_bit}};
            end
        end
        if (s1_err || s1_we) begin
            asm_data = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else if (s1_advance) begin
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= asm_data;
            rsp_err_o   <= s1_err;
        end else if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_banked_lane_memory.sv
// tb/tb_banked_lane_memory.sv - directed self-checking bench for banked_lane_memory

module tb_banked_lane_memory;
    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          req_valid;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [SW-1:0] req_size;
    logic          req_sext;
    logic [DW-1:0] req_wdata;
    logic          rsp_ready;

    logic          req_ready_a, rsp_valid_a, rsp_err_a;
    logic [DW-1:0] rsp_rdata_a;
    logic          req_ready_b, rsp_valid_b, rsp_err_b;
    logic [DW-1:0] rsp_rdata_b;

    always #5 clk = ~clk;

    banked_lane_memory #(
        .NumLanes (N), .AddrWidth (AW), .AllowMisaligned (1'b1), .MemFilePrefix ("data_")
    ) u_dut (
        .clk_i (clk), .rst_i (rst_i),
        .req_valid_i (req_valid), .req_ready_o (req_ready_a), .req_we_i (req_we),
        .req_addr_i (req_addr), .req_size_i (req_size), .req_sext_i (req_sext),
        .req_wdata_i (req_wdata), .rsp_valid_o (rsp_valid_a), .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata_a), .rsp_err_o (rsp_err_a)
    );

    banked_lane_memory #(
        .NumLanes (N), .AddrWidth (AW), .AllowMisaligned (1'b0), .MemFilePrefix ("data_")
    ) u_dut_aligned (
        .clk_i (clk), .rst_i (rst_i),
        .req_valid_i (req_valid), .req_ready_o (req_ready_b), .req_we_i (req_we),
        .req_addr_i (req_addr), .req_size_i (req_size), .req_sext_i (req_sext),
        .req_wdata_i (req_wdata), .rsp_valid_o (rsp_valid_b), .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata_b), .rsp_err_o (rsp_err_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    logic          q_we     [16];
    logic [AW-1:0] q_addr   [16];
    logic [SW-1:0] q_size   [16];
    logic          q_sext   [16];
    logic [DW-1:0] q_wdata  [16];
    logic [DW-1:0] q_exp    [16];
    logic          q_experr [16];
    logic          rb_err   [16];
    int            n_q = 0;
    int            drop_at;
    int            first_rsp_cyc;
    int            last_cycles;

    task automatic add(input logic we, input logic [AW-1:0] addr, input logic [SW-1:0] size,
                       input logic sext, input logic [DW-1:0] wdata, input logic [DW-1:0] exp,
                       input logic experr);
        q_we[n_q] = we; q_addr[n_q] = addr; q_size[n_q] = size; q_sext[n_q] = sext;
        q_wdata[n_q] = wdata; q_exp[n_q] = exp; q_experr[n_q] = experr;
        n_q++;
    endtask

    // Runs queued requests back-to-back; rsp_ready is held low for the first stall_cycles cycles.
    task automatic run_stream(input string tag, input int stall_cycles);
        int            sent, got, cyc;
        logic          rdy, rv, held_v;
        logic [DW-1:0] held;
        sent = 0; got = 0; cyc = 0; held_v = 1'b0; held = '0;
        drop_at = -1; first_rsp_cyc = -1;
        while (got < n_q && cyc < 60) begin
            req_valid = (sent < n_q);
            if (sent < n_q) begin
                req_we = q_we[sent]; req_addr = q_addr[sent]; req_size = q_size[sent];
                req_sext = q_sext[sent]; req_wdata = q_wdata[sent];
            end
            rsp_ready = (cyc >= stall_cycles);
            #1;
            rdy = req_ready_a;
            rv  = rsp_valid_a;
            if (rv && first_rsp_cyc < 0) first_rsp_cyc = cyc;
            if (!rdy && drop_at < 0) drop_at = sent;
            if (held_v) check($sformatf("%s_hold%0d", tag, got), rsp_rdata_a, held);
            held_v = rv && !rsp_ready;
            held   = rsp_rdata_a;
            if (rv && rsp_ready) begin
                check($sformatf("%s_rd%0d", tag, got), rsp_rdata_a, q_exp[got]);
                check($sformatf("%s_err%0d", tag, got), 32'(rsp_err_a), 32'(q_experr[got]));
                rb_err[got] = rsp_err_b;
                got++;
            end
            @(posedge clk); #1;
            if (req_valid && rdy) sent++;
            cyc++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        check($sformatf("%s_done", tag), 32'(got), 32'(n_q));
        last_cycles = cyc;
        n_q = 0;
    endtask

    initial begin
        int max_v;
        rst_i = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
        req_sext = 1'b0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready_a), 32'd1);
        check("rst_valid", 32'(rsp_valid_a), 32'd0);
        check("rst_rdata", rsp_rdata_a, 32'd0);
        check("rst_err", 32'(rsp_err_a), 32'd0);
        rst_i = 1'b1;

        add(1, 12'h100, 2, 0, 32'hDEADBEEF, 32'h0, 0);
        run_stream("st1", 0);
        add(0, 12'h100, 2, 0, 32'h0, 32'hDEADBEEF, 0);
        run_stream("ld1", 0);
        check("ld1_latency", 32'(first_rsp_cyc), 32'd2);
        check("ld1_cycles", 32'(last_cycles), 32'd3);

        add(1, 12'h103, 2, 0, 32'h11223344, 32'h0, 0);
        add(0, 12'h103, 2, 0, 32'h0, 32'h11223344, 0);
        add(0, 12'h104, 0, 1, 32'h0, 32'h00000033, 0);
        add(0, 12'h103, 0, 0, 32'h0, 32'h00000044, 0);
        add(0, 12'h105, 1, 0, 32'h0, 32'h00001122, 0);
        run_stream("mis", 0);
        check("mis_cycles", 32'(last_cycles), 32'd7);

        add(1, 12'h020, 0, 0, 32'h00000080, 32'h0, 0);
        add(0, 12'h020, 0, 1, 32'h0, 32'hFFFFFF80, 0);
        add(0, 12'h020, 0, 0, 32'h0, 32'h00000080, 0);
        add(1, 12'h022, 1, 0, 32'h0000FF7F, 32'h0, 0);
        add(0, 12'h022, 1, 1, 32'h0, 32'hFFFFFF7F, 0);
        add(0, 12'h100, 2, 1, 32'h0, 32'h44ADBEEF, 0);
        run_stream("sext", 0);

        add(1, 12'hFFE, 1, 0, 32'h0000A5C3, 32'h0, 0);
        add(1, 12'hFFE, 2, 0, 32'h12345678, 32'h0, 1);
        add(0, 12'hFFE, 1, 0, 32'h0, 32'h0000A5C3, 0);
        add(0, 12'h000, 3, 0, 32'h0, 32'h0, 1);
        add(0, 12'hFFF, 0, 0, 32'h0, 32'h000000A5, 0);
        add(0, 12'hFFF, 1, 0, 32'h0, 32'h0, 1);
        run_stream("err", 0);

        add(0, 12'h102, 2, 0, 32'h0, 32'h223344AD, 0);
        add(0, 12'h100, 2, 0, 32'h0, 32'h44ADBEEF, 0);
        add(0, 12'h102, 1, 0, 32'h0, 32'h000044AD, 0);
        add(0, 12'h101, 1, 0, 32'h0, 32'h0000ADBE, 0);
        add(0, 12'h103, 0, 0, 32'h0, 32'h00000044, 0);
        run_stream("aln", 0);
        check("aln_b0", 32'(rb_err[0]), 32'd1);
        check("aln_b1", 32'(rb_err[1]), 32'd0);
        check("aln_b2", 32'(rb_err[2]), 32'd0);
        check("aln_b3", 32'(rb_err[3]), 32'd1);
        check("aln_b4", 32'(rb_err[4]), 32'd0);

        add(1, 12'h200, 2, 0, 32'hA0A1A2A3, 32'h0, 0);
        add(1, 12'h204, 2, 0, 32'hB0B1B2B3, 32'h0, 0);
        add(1, 12'h208, 2, 0, 32'hC0C1C2C3, 32'h0, 0);
        add(1, 12'h20C, 2, 0, 32'hD0D1D2D3, 32'h0, 0);
        run_stream("bpw", 0);
        add(0, 12'h200, 2, 0, 32'h0, 32'hA0A1A2A3, 0);
        add(0, 12'h202, 2, 0, 32'h0, 32'hB2B3A0A1, 0);
        add(0, 12'h20A, 1, 1, 32'h0, 32'hFFFFC0C1, 0);
        add(0, 12'h20C, 2, 0, 32'h0, 32'hD0D1D2D3, 0);
        run_stream("bp", 5);
        check("bp_drop_at", 32'(drop_at), 32'd2);
        check("bp_cycles", 32'(last_cycles), 32'd9);

        add(1, 12'h300, 2, 0, 32'h5A5A5A5A, 32'h0, 0);
        run_stream("rst_st", 0);
        req_we = 1'b0; req_size = 2; req_sext = 1'b0; req_addr = 12'h200; req_valid = 1'b1;
        @(posedge clk); #1;
        req_addr = 12'h204;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_inflight", 32'(rsp_valid_a), 32'd1);
        rst_i = 1'b0;
        #1;
        check("rst_mid_valid", 32'(rsp_valid_a), 32'd0);
        check("rst_mid_ready", 32'(req_ready_a), 32'd1);
        check("rst_mid_rdata", rsp_rdata_a, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b1;
        max_v = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (rsp_valid_a) max_v = 1;
        end
        check("rst_no_stale", 32'(max_v), 32'd0);
        add(0, 12'h300, 2, 0, 32'h0, 32'h5A5A5A5A, 0);
        add(0, 12'h200, 2, 0, 32'h0, 32'hA0A1A2A3, 0);
        run_stream("post_rst", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
